// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - shared delta-sigma loop constants and quantizer state type.
package ds_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    CLEAR   = 2'd1,
    RECOVER = 2'd2
  } ds_qstate_t;

  localparam int                 DS_IN_W        = 16;
  localparam logic signed [15:0] DS_FB_MAG      = 16'sh4000;
  localparam logic signed [15:0] DS_OVL_THRESH  = 16'sh7000;
  localparam int                 DS_OVL_COUNT   = 8;
  localparam int                 DS_RECOVER_LEN = 16;

endpackage

// File: rtl/ds_ovl_fsm.sv
// rtl/ds_ovl_fsm.sv - overload detector: run/recovery counters, clear request,
// overload flag and event counter.
module ds_ovl_fsm
  import ds_pkg::*;
#(
  parameter int OVL_COUNT   = DS_OVL_COUNT,
  parameter int RECOVER_LEN = DS_RECOVER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic       over,
  output logic       force_en,
  output logic       force_bit,
  output logic       ovl,
  output logic       loop_clear,
  output logic [7:0] ovl_events
);

  ds_qstate_t state, state_n;
  logic [7:0] run, run_n;
  logic [7:0] rec, rec_n;

  // Samples taken in CLEAR or RECOVER use the forced pattern, first bit 1.
  assign force_en  = (state != NORMAL);
  assign force_bit = ~rec[0];

  always_comb begin
    state_n = state;
    run_n   = run;
    rec_n   = rec;
    case (state)
      NORMAL: begin
        if (valid) begin
          if (over) begin
            run_n = run + 8'd1;
            if (run + 8'd1 == 8'(OVL_COUNT)) state_n = CLEAR;
          end else begin
            run_n = 8'd0;
          end
        end
      end
      CLEAR, RECOVER: begin
        run_n = 8'd0;
        if (state == CLEAR) state_n = RECOVER;
        if (valid) begin
          if (rec + 8'd1 == 8'(RECOVER_LEN)) begin
            rec_n   = 8'd0;
            state_n = NORMAL;
          end else begin
            rec_n = rec + 8'd1;
          end
        end
      end
      default: state_n = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= NORMAL;
      run        <= 8'd0;
      rec        <= 8'd0;
      ovl        <= 1'b0;
      loop_clear <= 1'b0;
      ovl_events <= 8'd0;
    end else begin
      state      <= state_n;
      run        <= run_n;
      rec        <= rec_n;
      ovl        <= (state_n != NORMAL);
      loop_clear <= (state == NORMAL) && (state_n == CLEAR);
      if ((state == NORMAL) && (state_n == CLEAR) && (ovl_events != 8'hFF))
        ovl_events <= ovl_events + 8'd1;
    end
  end

endmodule

// File: rtl/ds_quantizer.sv
// rtl/ds_quantizer.sv - single-bit quantizer with feedback value and
// overload recovery, downstream of the second loop-filter integrator.
module ds_quantizer
  import ds_pkg::*;
#(
  parameter int                       IN_W        = DS_IN_W,
  parameter logic signed [IN_W-1:0]   FB_MAG      = DS_FB_MAG,
  parameter logic signed [IN_W-1:0]   OVL_THRESH  = DS_OVL_THRESH,
  parameter int                       OVL_COUNT   = DS_OVL_COUNT,
  parameter int                       RECOVER_LEN = DS_RECOVER_LEN
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic signed [IN_W-1:0] fb,
  output logic                   ovl,
  output logic                   loop_clear,
  output logic [7:0]             ovl_events
);

  logic [IN_W:0] ext;
  logic [IN_W:0] mag;
  logic          over;
  logic          force_en;
  logic          force_bit;
  logic          bit_n;

  // One extra bit so that |most-negative| is representable and counts as over.
  assign ext   = {in[IN_W-1], in};
  assign mag   = in[IN_W-1] ? (~ext + (IN_W+1)'(1)) : ext;
  assign over  = (mag >= {1'b0, OVL_THRESH});
  assign bit_n = force_en ? force_bit : ~in[IN_W-1];

  ds_ovl_fsm #(
    .OVL_COUNT  (OVL_COUNT),
    .RECOVER_LEN(RECOVER_LEN)
  ) u_fsm (
    .clk       (CLK),
    .reset     (reset),
    .valid     (in_valid),
    .over      (over),
    .force_en  (force_en),
    .force_bit (force_bit),
    .ovl       (ovl),
    .loop_clear(loop_clear),
    .ovl_events(ovl_events)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      fb        <= '0;
    end else begin
      bit_valid <= in_valid;
      if (in_valid) begin
        bit_out <= bit_n;
        fb      <= bit_n ? FB_MAG : -FB_MAG;
      end
    end
  end

endmodule

// File: tb/tb_ds_quantizer.sv
// tb/tb_ds_quantizer.sv - directed vector bench for ds_quantizer.
module tb_ds_quantizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] din;
  logic        bit_out;
  logic        bit_valid;
  logic [15:0] fb;
  logic        ovl;
  logic        loop_clear;
  logic [7:0]  ovl_events;

  int n_cmp = 0;
  int n_err = 0;

  ds_quantizer dut (
    .CLK       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (din),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .fb        (fb),
    .ovl       (ovl),
    .loop_clear(loop_clear),
    .ovl_events(ovl_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        eb;
    logic [15:0] efb;
    logic        ev;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d);
    in_valid = v;
    din      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_sample(input string name, input logic eb);
    check({name, ".bit"}, 32'(bit_out), 32'(eb));
    check({name, ".fb"},  32'(fb), eb ? 32'h4000 : 32'hC000);
  endtask

  initial begin
    logic bad;

    vt[0] = '{1'b1, 16'h0000, 1'b1, 16'h4000, 1'b1};
    vt[1] = '{1'b1, 16'hFFFF, 1'b0, 16'hC000, 1'b1};
    vt[2] = '{1'b1, 16'h0001, 1'b1, 16'h4000, 1'b1};
    vt[3] = '{1'b1, 16'h8000, 1'b0, 16'hC000, 1'b1};
    vt[4] = '{1'b0, 16'h0001, 1'b0, 16'hC000, 1'b0};
    vt[5] = '{1'b1, 16'h0000, 1'b1, 16'h4000, 1'b1};
    vt[6] = '{1'b1, 16'h6FFF, 1'b1, 16'h4000, 1'b1};
    vt[7] = '{1'b1, 16'h9001, 1'b0, 16'hC000, 1'b1};

    reset    = 1'b0;
    in_valid = 1'b1;
    din      = 16'h7FFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst.bit_out", 32'(bit_out), 32'd0);
    check("rst.bit_valid", 32'(bit_valid), 32'd0);
    check("rst.fb", 32'(fb), 32'd0);
    check("rst.ovl", 32'(ovl), 32'd0);
    check("rst.loop_clear", 32'(loop_clear), 32'd0);
    check("rst.ovl_events", 32'(ovl_events), 32'd0);
    reset = 1'b1;
    step(1'b1, 16'h7FFF);
    check("first.valid", 32'(bit_valid), 32'd1);
    check_sample("first", 1'b1);

    for (int i = 0; i < 8; i++) begin
      step(vt[i].v, vt[i].d);
      check($sformatf("vec%0d.bit", i), 32'(bit_out), 32'(vt[i].eb));
      check($sformatf("vec%0d.fb", i), 32'(fb), 32'(vt[i].efb));
      check($sformatf("vec%0d.valid", i), 32'(bit_valid), 32'(vt[i].ev));
      check($sformatf("vec%0d.ovl", i), 32'(ovl), 32'd0);
    end

    // Overload on the 8th over-threshold sample, then 16-sample recovery.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'h7400);
      check($sformatf("ovl8.lc%0d", i), 32'(loop_clear), (i == 7) ? 32'd1 : 32'd0);
    end
    check("ovl8.ovl", 32'(ovl), 32'd1);
    check("ovl8.events", 32'(ovl_events), 32'd1);
    check_sample("ovl8.last", 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'h7400);
      check_sample($sformatf("rec%0d", i), (i % 2) == 0);
      check($sformatf("rec%0d.ovl", i), 32'(ovl), (i != 15) ? 32'd1 : 32'd0);
      if (i == 0) check("rec0.lc", 32'(loop_clear), 32'd0);
    end
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 16'h7400);
      bad = bad | loop_clear | ovl | ~bit_out;
    end
    check("post_rec.normal", 32'(bad), 32'd0);
    check("post_rec.events", 32'(ovl_events), 32'd1);
    step(1'b1, 16'h0100);

    // A single under-threshold sample restarts the run.
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, (i == 7) ? 16'h0100 : 16'h7400);
      bad = bad | loop_clear | ovl;
    end
    check("run_broken", 32'(bad), 32'd0);
    step(1'b1, 16'h0100);

    // |-0x7000| sits exactly on the threshold.
    for (int i = 0; i < 8; i++) step(1'b1, (i == 7) ? 16'h9000 : 16'h7000);
    check("thresh.lc", 32'(loop_clear), 32'd1);
    check("thresh.ovl", 32'(ovl), 32'd1);
    check("thresh.events", 32'(ovl_events), 32'd2);

    // Recovery with in_valid toggling; negative input shows the pattern is forced.
    for (int c = 0; c < 32; c++) begin
      step((c % 2) == 0, 16'h8000);
      check($sformatf("gap%0d.valid", c), 32'(bit_valid), ((c % 2) == 0) ? 32'd1 : 32'd0);
      check_sample($sformatf("gap%0d", c), ((c / 2) % 2) == 0);
      check($sformatf("gap%0d.ovl", c), 32'(ovl), (c < 30) ? 32'd1 : 32'd0);
    end
    step(1'b1, 16'h8000);
    check_sample("gap.after", 1'b0);

    bad = 1'b0;
    step(1'b1, 16'h0100);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 7) ? 16'h9001 : 16'h7000);
      bad = bad | loop_clear | ovl;
    end
    check("below_thresh", 32'(bad), 32'd0);
    step(1'b1, 16'h0100);

    // Reset in the middle of recovery.
    for (int i = 0; i < 8; i++) step(1'b1, 16'h7400);
    check("mid.events", 32'(ovl_events), 32'd3);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h7400);
    check_sample("mid.rec5", 1'b1);
    reset = 1'b0;
    #2;
    check("mid.rst.bit", 32'(bit_out), 32'd0);
    check("mid.rst.valid", 32'(bit_valid), 32'd0);
    check("mid.rst.fb", 32'(fb), 32'd0);
    check("mid.rst.ovl", 32'(ovl), 32'd0);
    check("mid.rst.lc", 32'(loop_clear), 32'd0);
    check("mid.rst.events", 32'(ovl_events), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 16'h7400);
    check_sample("mid.after", 1'b1);
    check("mid.after.ovl", 32'(ovl), 32'd0);
    check("mid.after.events", 32'(ovl_events), 32'd0);
    check("mid.after.lc", 32'(loop_clear), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ds_quantizer.md
# ds_quantizer

Single-bit quantizer stage of the delta-sigma modulator, sitting directly downstream of the second loop-filter integrator (`h2_block`). It turns the signed 16-bit loop-filter output into the modulator bitstream and the matching signed feedback value returned to the loop-filter inputs. It also detects loop overload, requests an integrator clear, and forces a zero-mean recovery pattern until the loop re-settles.

## Interface
Parameters:
- `IN_W`, 16: width of the loop-filter sample and of the feedback value.
- `FB_MAG`, 16'sh4000: magnitude of the feedback value (±FB_MAG).
- `OVL_THRESH`, 16'sh7000: overload threshold on |in|.
- `OVL_COUNT`, 8: number of consecutive over-threshold valid samples that declares an overload (range 1–255).
- `RECOVER_LEN`, 16: number of valid samples in the forced recovery pattern (range 1–255).

Ports:
- `CLK` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in` carries a new sample this cycle.
- `in` in IN_W: signed two's-complement loop-filter output.
- `bit_out` out 1: modulator output bit.
- `bit_valid` out 1: one-cycle strobe; `bit_out`/`fb` updated this cycle.
- `fb` out IN_W: signed feedback value, +FB_MAG when bit=1, −FB_MAG when bit=0.
- `ovl` out 1: high while in CLEAR or RECOVER state.
- `loop_clear` out 1: one-cycle pulse requesting the upstream integrators to clear.
- `ovl_events` out 8: saturating count of overload events since reset.

## Operation
- Reset values (while `reset`=0): `bit_out`=0, `bit_valid`=0, `fb`=0, `ovl`=0, `loop_clear`=0, `ovl_events`=0, FSM=NORMAL, all internal counters 0.
- Quantization in NORMAL: bit = (in >= 0). Zero maps to 1.
- Magnitude: |in| computed in IN_W+1 bits. −32768 counts as over threshold. The over-threshold test is |in| >= OVL_THRESH.
- When `in_valid`=0: `bit_out` and `fb` hold, `bit_valid`=0, and the FSM counters do not advance.
- FSM states:
  - NORMAL: the run counter increments on each valid over-threshold sample and clears on each valid under-threshold sample. When a valid sample brings the run to OVL_COUNT, go to CLEAR. That sample is still quantized normally.
  - CLEAR: lasts exactly one cycle. `loop_clear`=1 and `ovl`=1. `ovl_events` increments and saturates at 255. The run counter clears. Go to RECOVER.
  - RECOVER: `ovl`=1. Each valid sample, including one arriving during the CLEAR cycle, outputs the forced pattern 1,0,1,0,… starting with 1, regardless of `in`. `fb` follows the forced bit. After RECOVER_LEN valid pattern samples, go to NORMAL with `ovl`=0.
- Over-threshold samples are ignored for detection during CLEAR and RECOVER. The run count restarts from 0 in NORMAL.
- Reset asserted mid-operation: all outputs and the FSM return to their reset values immediately (asynchronous). The recovery pattern does not resume.

## Timing
- All outputs are registered.
- Latency: a sample accepted at edge k appears on `bit_out`/`fb` with `bit_valid`=1 after edge k, for one cycle.
- Overload at edge k (the OVL_COUNT-th sample): `loop_clear` and `ovl` are high after edge k; `loop_clear` drops after edge k+1.
- The last recovery sample at edge m: `ovl`=0 after edge m. The sample at edge m+1 is quantized normally.
- Throughput is one sample per cycle; `in_valid` may be high continuously.

## Structure
- Package `ds_pkg` holds:
  - the state enum `ds_qstate_t` (NORMAL, CLEAR, RECOVER);
  - the default constants for IN_W, FB_MAG, OVL_THRESH, OVL_COUNT and RECOVER_LEN.
  - `h2_block` and any loop-filter siblings share the IN_W and FB_MAG constants from this package.
- Sub-module `ds_ovl_fsm` holds the FSM, the run and recovery counters, `loop_clear`/`ovl` generation and `ovl_events`. The top level holds the magnitude compare, the quantizer and the output registers.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `in`=16'h7FFF and `in_valid`=1 → all outputs 0, `fb`=0; after release, first `bit_out`=1 and `fb`=16'h4000 one cycle after the first valid sample.
- Sign mapping: valid samples 16'h0000, 16'hFFFF, 16'h0001, 16'h8000 → bits 1,0,1,0 and `fb` = 4000, C000, 4000, C000, each one cycle later.
- Overload: 8 consecutive valid samples of 16'h7400 → `loop_clear` pulses once, `ovl`=1 and `ovl_events`=1, all after the 8th sample's edge. Then 16 valid samples of 16'h7400 → bits 1,0,1,0,… then `ovl`=0.
- Run broken: 7 valid samples of 16'h7400, one of 16'h0100, 7 more of 16'h7400 → no `loop_clear`, `ovl` stays 0.
- Gaps: `in_valid` toggling 1,0,1,0 during RECOVER → `bit_valid` only on valid cycles, outputs hold between them, and recovery takes 16 valid samples (32 cycles).
- Reset mid-RECOVER: assert `reset` after 5 recovery samples → outputs return to reset values; after release, 16'h7400 input is quantized normally (bit 1) with `ovl`=0 and `ovl_events`=0.
